pingpong_match_ctrl: RTL and testbench

Match-level controller that sequences the ping-pong rally engine. It arms each serve and latches the ball speed for it. It accepts point-won events from the rally engine, keeps game and set scores, inserts a post-point delay, supports pause, and declares a best-of-N-sets winner. The rally engine owns the LEDs and ball movement. This block tells it when to launch, in which direction and at what base speed, and when to freeze.

---
 rtl/pingpong_match_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pingpong_match_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pingpong_match_ctrl.sv
// rtl/pingpong_match_ctrl.sv - match-level sequencer for the ping-pong rally engine
// Arms serves, keeps game/set score, times the post-point delay, handles pause.
module pingpong_match_ctrl #(
  parameter int POINTS_TO_WIN = 7,
  parameter int SETS_TO_WIN   = 2,
  parameter int DELAY_TICKS   = 250
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       start,
  input  logic       pause_tgl,
  input  logic       serve0,
  input  logic       serve1,
  input  logic       pt_p1,
  input  logic       pt_p2,
  input  logic [1:0] speed_sel,
  output logic       serve_go,
  output logic       serve_dir,
  output logic       rally_en,
  output logic [8:0] base_maxT,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic [1:0] sets1,
  output logic [1:0] sets2,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SERVE_WAIT  = 3'd1,
    S_RALLY       = 3'd2,
    S_POINT_DELAY = 3'd3,
    S_PAUSE       = 3'd4,
    S_MATCH_OVER  = 3'd5
  } state_t;

  localparam int         CW      = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;
  localparam logic [2:0] PTS_WIN = 3'(POINTS_TO_WIN);
  localparam logic [1:0] SET_WIN = 2'(SETS_TO_WIN);
  localparam logic       SRV_P1  = 1'b0;
  localparam logic       SRV_P2  = 1'b1;

  state_t          state_q, state_d;
  logic [2:0]      score1_q, score1_d, score2_q, score2_d;
  logic [1:0]      sets1_q, sets1_d, sets2_q, sets2_d;
  logic [1:0]      winner_q, winner_d;
  logic            server_q, server_d;
  logic            serve_go_q, serve_go_d;
  logic            serve_dir_q, serve_dir_d;
  logic [8:0]      base_maxt_q, base_maxt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            serve_hit;

  function automatic logic [8:0] speed_to_maxt(input logic [1:0] sel);
    case (sel)
      2'b11:   speed_to_maxt = 9'd50;
      2'b10:   speed_to_maxt = 9'd100;
      2'b01:   speed_to_maxt = 9'd200;
      default: speed_to_maxt = 9'd400;
    endcase
  endfunction

  // Only the current server's button counts; the receiver's button is dead.
  assign serve_hit = (server_q == SRV_P1) ? serve0 : serve1;

  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    sets1_d     = sets1_q;
    sets2_d     = sets2_q;
    winner_d    = winner_q;
    server_d    = server_q;
    serve_go_d  = 1'b0;
    serve_dir_d = serve_dir_q;
    base_maxt_d = base_maxt_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE, S_MATCH_OVER: begin
        if (start) begin
          score1_d = '0;
          score2_d = '0;
          sets1_d  = '0;
          sets2_d  = '0;
          winner_d = '0;
          server_d = SRV_P1;
          state_d  = S_SERVE_WAIT;
        end
      end
      S_SERVE_WAIT: begin
        if (serve_hit) begin
          base_maxt_d = speed_to_maxt(speed_sel);
          serve_dir_d = (server_q == SRV_P1);
          serve_go_d  = 1'b1;
          state_d     = S_RALLY;
        end
      end
      S_RALLY: begin
        if (pt_p1 || pt_p2) begin
          // Simultaneous pulses are a let: no score change, same server.
          if (pt_p1 && !pt_p2) begin
            score1_d = score1_q + 3'd1;
            server_d = SRV_P2;
          end else if (pt_p2 && !pt_p1) begin
            score2_d = score2_q + 3'd1;
            server_d = SRV_P1;
          end
          cnt_d   = CW'(DELAY_TICKS - 1);
          state_d = S_POINT_DELAY;
        end else if (pause_tgl) begin
          state_d = S_PAUSE;
        end
      end
      S_POINT_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_SERVE_WAIT;
          if (score1_q == PTS_WIN) begin
            sets1_d  = sets1_q + 2'd1;
            score1_d = '0;
            score2_d = '0;
            server_d = SRV_P2;
            if (sets1_q + 2'd1 == SET_WIN) begin
              winner_d = 2'b01;
              state_d  = S_MATCH_OVER;
            end
          end else if (score2_q == PTS_WIN) begin
            sets2_d  = sets2_q + 2'd1;
            score1_d = '0;
            score2_d = '0;
            server_d = SRV_P1;
            if (sets2_q + 2'd1 == SET_WIN) begin
              winner_d = 2'b10;
              state_d  = S_MATCH_OVER;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PAUSE: begin
        if (pause_tgl) state_d = S_RALLY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      score1_q    <= '0;
      score2_q    <= '0;
      sets1_q     <= '0;
      sets2_q     <= '0;
      winner_q    <= '0;
      server_q    <= SRV_P1;
      serve_go_q  <= 1'b0;
      serve_dir_q <= 1'b1;
      base_maxt_q <= 9'd400;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      sets1_q     <= sets1_d;
      sets2_q     <= sets2_d;
      winner_q    <= winner_d;
      server_q    <= server_d;
      serve_go_q  <= serve_go_d;
      serve_dir_q <= serve_dir_d;
      base_maxt_q <= base_maxt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign serve_go  = serve_go_q;
  assign serve_dir = serve_dir_q;
  assign rally_en  = (state_q == S_RALLY);
  assign base_maxT = base_maxt_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign sets1     = sets1_q;
  assign sets2     = sets2_q;
  assign winner    = winner_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pingpong_match_ctrl.sv
// tb/tb_pingpong_match_ctrl.sv - directed-vector bench for pingpong_match_ctrl
module tb_pingpong_match_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       start = 1'b0, pause_tgl = 1'b0, serve0 = 1'b0, serve1 = 1'b0;
  logic       pt_p1 = 1'b0, pt_p2 = 1'b0;
  logic [1:0] speed_sel = 2'b00;
  logic       serve_go, serve_dir, rally_en;
  logic [8:0] base_maxT;
  logic [2:0] score1, score2, state_o;
  logic [1:0] sets1, sets2, winner;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  pingpong_match_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .pause_tgl(pause_tgl),
    .serve0(serve0), .serve1(serve1), .pt_p1(pt_p1), .pt_p2(pt_p2),
    .speed_sel(speed_sel), .serve_go(serve_go), .serve_dir(serve_dir),
    .rally_en(rally_en), .base_maxT(base_maxT), .score1(score1), .score2(score2),
    .sets1(sets1), .sets2(sets2), .winner(winner), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic pulse_serve(input bit p2);
    if (p2) serve1 = 1'b1; else serve0 = 1'b1;
    step();
    serve0 = 1'b0;
    serve1 = 1'b0;
  endtask

  task automatic pulse_in(input bit p1, input bit p2, input bit pt);
    pt_p1 = p1; pt_p2 = p2; pause_tgl = pt;
    step();
    pt_p1 = 1'b0; pt_p2 = 1'b0; pause_tgl = 1'b0;
  endtask

  task automatic wait_delay(input string tag, input int exit_st);
    int n = 0;
    while (state_o == 3'd3 && n < 1000) begin
      n++;
      step();
    end
    chk(tag, n, 250);
    chk({tag, "_exit"}, int'(state_o), exit_st);
  endtask

  task automatic play_point(input bit srv_p2, input bit p2_wins, input int exit_st);
    pulse_serve(srv_p2);
    chk("pp_serve_go", int'(serve_go), 1);
    pulse_in(!p2_wins, p2_wins, 1'b0);
    wait_delay("pp_delay", exit_st);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step(); step();
    chk("rst_state", int'(state_o), 0);
    chk("rst_rally_en", int'(rally_en), 0);
    chk("rst_serve_go", int'(serve_go), 0);
    chk("rst_dir", int'(serve_dir), 1);
    chk("rst_maxt", int'(base_maxT), 400);
    chk("rst_score1", int'(score1), 0);
    chk("rst_winner", int'(winner), 0);
    RSTn = 1'b1;
    step();

    start = 1'b1; step(); start = 1'b0;
    chk("start_state", int'(state_o), 1);
    pulse_serve(1'b1);
    chk("wrong_srv_state", int'(state_o), 1);
    chk("wrong_srv_go", int'(serve_go), 0);
    speed_sel = 2'b00;
    pulse_serve(1'b0);
    chk("srv0_go", int'(serve_go), 1);
    chk("srv0_dir", int'(serve_dir), 1);
    chk("srv0_maxt", int'(base_maxT), 400);
    chk("srv0_state", int'(state_o), 2);
    chk("srv0_rally_en", int'(rally_en), 1);
    step();
    chk("go_one_cycle", int'(serve_go), 0);

    pulse_in(1'b1, 1'b0, 1'b0);
    chk("pt1_score1", int'(score1), 1);
    chk("pt1_state", int'(state_o), 3);
    chk("pt1_rally_en", int'(rally_en), 0);
    wait_delay("pt1_delay", 1);
    pulse_serve(1'b0);
    chk("p2srv_ignore_state", int'(state_o), 1);
    chk("p2srv_ignore_go", int'(serve_go), 0);
    speed_sel = 2'b11;
    pulse_serve(1'b1);
    chk("srv1_go", int'(serve_go), 1);
    chk("srv1_dir", int'(serve_dir), 0);
    chk("srv1_maxt", int'(base_maxT), 50);

    pulse_in(1'b1, 1'b1, 1'b0);
    chk("let_state", int'(state_o), 3);
    chk("let_score1", int'(score1), 1);
    chk("let_score2", int'(score2), 0);
    wait_delay("let_delay", 1);
    pulse_serve(1'b0);
    chk("let_server_keep", int'(state_o), 1);
    pulse_serve(1'b1);
    chk("let_srv1_state", int'(state_o), 2);

    pulse_in(1'b0, 1'b0, 1'b1);
    chk("pause_state", int'(state_o), 4);
    chk("pause_rally_en", int'(rally_en), 0);
    pulse_in(1'b1, 1'b0, 1'b0);
    chk("pause_pt_score1", int'(score1), 1);
    chk("pause_pt_state", int'(state_o), 4);
    pulse_in(1'b0, 1'b0, 1'b1);
    chk("resume_state", int'(state_o), 2);
    chk("resume_rally_en", int'(rally_en), 1);
    pulse_in(1'b0, 1'b1, 1'b1);
    chk("pt_over_pause_state", int'(state_o), 3);
    chk("pt_over_pause_score2", int'(score2), 1);
    wait_delay("pp_delay1", 1);

    // Score 1-1, P1 serving; P2 takes six more points to close the set.
    for (int i = 0; i < 6; i++) play_point(1'b0, 1'b1, 1);
    chk("set1_sets2", int'(sets2), 1);
    chk("set1_score1", int'(score1), 0);
    chk("set1_score2", int'(score2), 0);
    pulse_serve(1'b1);
    chk("set1_server_p1", int'(state_o), 1);

    for (int i = 0; i < 6; i++) play_point(1'b0, 1'b1, 1);
    play_point(1'b0, 1'b1, 5);
    chk("match_winner", int'(winner), 2);
    chk("match_sets2", int'(sets2), 2);
    chk("match_rally_en", int'(rally_en), 0);
    pulse_serve(1'b0);
    chk("over_serve_go", int'(serve_go), 0);
    pulse_in(1'b1, 1'b0, 1'b0);
    pulse_in(1'b0, 1'b0, 1'b1);
    chk("over_state", int'(state_o), 5);
    chk("over_score1", int'(score1), 0);
    chk("over_winner_hold", int'(winner), 2);

    start = 1'b1; step(); start = 1'b0;
    chk("restart_state", int'(state_o), 1);
    chk("restart_sets2", int'(sets2), 0);
    chk("restart_winner", int'(winner), 0);

    play_point(1'b0, 1'b0, 1);
    for (int i = 0; i < 6; i++) play_point(1'b1, 1'b0, 1);
    chk("p1set_sets1", int'(sets1), 1);
    speed_sel = 2'b10;
    for (int i = 0; i < 4; i++) play_point(1'b1, 1'b0, 1);
    pulse_serve(1'b1);
    chk("mid_maxt", int'(base_maxT), 100);
    chk("mid_dir", int'(serve_dir), 0);
    pulse_in(1'b1, 1'b0, 1'b0);
    repeat (10) step();
    chk("mid_state", int'(state_o), 3);
    chk("mid_score1", int'(score1), 5);
    chk("mid_sets1", int'(sets1), 1);
    RSTn = 1'b0;
    step();
    chk("mid_rst_state", int'(state_o), 0);
    chk("mid_rst_score1", int'(score1), 0);
    chk("mid_rst_sets1", int'(sets1), 0);
    chk("mid_rst_maxt", int'(base_maxT), 400);
    chk("mid_rst_dir", int'(serve_dir), 1);
    chk("mid_rst_rally_en", int'(rally_en), 0);
    RSTn = 1'b1;
    step();
    chk("post_rst_idle", int'(state_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
